// File: rtl/i2c_target_regs.sv
// I2C target register responder: filtered, oversampled bus decode with pointer auto-increment.
// Define I2C_GENERAL_CALL_EN to ACK the general call address (7'h00, write only).
module i2c_target_regs #(
  parameter logic [6:0] I2C_ADDR = 7'h50,
  parameter int         FILT_LEN = 4,
  parameter int         PTR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i2c_scl_i,
  output logic             i2c_scl_o,
  output logic             i2c_scl_t,
  input  logic             i2c_sda_i,
  output logic             i2c_sda_o,
  output logic             i2c_sda_t,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             busy
);

`ifdef I2C_GENERAL_CALL_EN
  localparam logic GC_EN = 1'b1;
`else
  localparam logic GC_EN = 1'b0;
`endif

  localparam logic [3:0]       FILT_MAX = 4'(FILT_LEN - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t state, state_n;

  logic [1:0]       scl_sync, sda_sync;
  logic [3:0]       scl_cnt, sda_cnt;
  logic             scl_f, sda_f, scl_d, sda_d;
  logic [7:0]       shreg;
  logic [7:0]       shin;
  logic [2:0]       bitcnt;
  logic             rw, gc;
  logic [PTR_W-1:0] ptr;
  logic             scl_rise, scl_fall, start_ev, stop_ev, last_bit;
  logic             own_hit, gc_hit;

  assign i2c_scl_o = 1'b0;
  assign i2c_scl_t = 1'b1;
  assign i2c_sda_o = 1'b0;
  assign rd_addr   = ptr;

  // A filtered level only flips once FILT_LEN consecutive synchronized samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], i2c_scl_i};
      sda_sync <= {sda_sync[0], i2c_sda_i};
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FILT_MAX) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 4'd1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FILT_MAX) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 4'd1;
      end
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start_ev = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_ev  = scl_f & scl_d & ~sda_d & sda_f;
  assign last_bit = (bitcnt == 3'd7);
  assign shin     = {shreg[6:0], sda_f};
  assign own_hit  = (shreg[6:0] == I2C_ADDR);
  assign gc_hit   = GC_EN && (shreg[6:0] == 7'h00) && !sda_f && !own_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start_ev) begin
      state_n = ADDR;
    end else if (stop_ev) begin
      state_n = IDLE;
    end else if (scl_rise) begin
      case (state)
        ADDR:      if (last_bit) state_n = (own_hit || gc_hit) ? ADDR_ACK : IDLE;
        ADDR_ACK:  state_n = rw ? RDATA : (gc ? WDATA : PTR);
        PTR:       if (last_bit) state_n = PTR_ACK;
        PTR_ACK:   state_n = WDATA;
        WDATA:     if (last_bit) state_n = WDATA_ACK;
        WDATA_ACK: state_n = WDATA;
        RDATA:     if (last_bit) state_n = RDATA_ACK;
        RDATA_ACK: state_n = sda_f ? IDLE : RDATA;
        default:   state_n = state;
      endcase
    end
  end

  // Bits are captured on filtered SCL rise; SDA is only ever changed on filtered SCL fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      bitcnt    <= '0;
      rw        <= 1'b0;
      gc        <= 1'b0;
      ptr       <= '0;
      i2c_sda_t <= 1'b1;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (start_ev) begin
        bitcnt    <= '0;
        gc        <= 1'b0;
        busy      <= 1'b0;
        i2c_sda_t <= 1'b1;
      end else if (stop_ev) begin
        gc        <= 1'b0;
        busy      <= 1'b0;
        i2c_sda_t <= 1'b1;
      end else if (scl_rise) begin
        case (state)
          ADDR, PTR, WDATA: begin
            shreg  <= shin;
            bitcnt <= bitcnt + 3'd1;
          end
          RDATA:   bitcnt <= bitcnt + 3'd1;
          default: bitcnt <= '0;
        endcase
        if (state == ADDR && last_bit && (own_hit || gc_hit)) begin
          rw   <= sda_f;
          gc   <= gc_hit;
          busy <= 1'b1;
        end
        if (state == PTR && last_bit) ptr <= PTR_W'(shin);
        if (state == WDATA_ACK) begin
          wr_en   <= 1'b1;
          wr_data <= shreg;
          wr_addr <= gc ? '1 : ptr;
          if (!gc) ptr <= ptr + PTR_ONE;
        end
        if (state == RDATA_ACK) ptr <= ptr + PTR_ONE;
      end else if (scl_fall) begin
        case (state)
          ADDR_ACK, PTR_ACK, WDATA_ACK: i2c_sda_t <= 1'b0;
          RDATA: begin
            if (bitcnt == 3'd0) begin
              shreg     <= rd_data;
              i2c_sda_t <= rd_data[7];
            end else begin
              shreg     <= {shreg[6:0], 1'b0};
              i2c_sda_t <= shreg[6];
            end
          end
          default: i2c_sda_t <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C controller, open-drain bus model and scoreboard queues.
`timescale 1ns/1ps
module tb_i2c_target_regs;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclDrv = 1'b1;
  logic       sdaDrv = 1'b1;
  logic       i2c_scl_o, i2c_scl_t, i2c_sda_o, i2c_sda_t;
  logic       sclLine, sdaLine;
  logic       wr_en, busy;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic [7:0] rd_data = 8'h00;

  int         assertCount = 0;
  int         failCount = 0;
  logic [15:0] expWr[$];
  logic        expAck[$];
  logic [7:0]  expRd[$];
  logic        lowSeen = 1'b0;
  logic        busySeen = 1'b0;
  logic [7:0]  partial;
  logic        bitVal;

  assign sclLine = sclDrv & (i2c_scl_t | i2c_scl_o);
  assign sdaLine = sdaDrv & (i2c_sda_t | i2c_sda_o);

  i2c_target_regs dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i2c_scl_i (sclLine),
    .i2c_scl_o (i2c_scl_o),
    .i2c_scl_t (i2c_scl_t),
    .i2c_sda_i (sdaLine),
    .i2c_sda_o (i2c_sda_o),
    .i2c_sda_t (i2c_sda_t),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Register file model: contents are the address inverted, one clock behind rd_addr.
  always @(posedge clk) rd_data <= rd_addr ^ 8'hFF;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!i2c_sda_t) lowSeen = 1'b1;
    if (busy) busySeen = 1'b1;
    if (wr_en) begin
      if (expWr.size() == 0) checkOutput("wr_extra", {31'b0, wr_en}, 32'h0);
      else checkOutput("wr_beat", {16'h0, wr_addr, wr_data}, {16'h0, expWr.pop_front()});
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic d, input int n);
    sclDrv = s;
    sdaDrv = d;
    waitClk(n);
  endtask

  task automatic i2cStart();
    applyStimulus(1'b0, 1'b1, Q);
    applyStimulus(1'b1, 1'b1, Q);
    applyStimulus(1'b1, 1'b0, Q);
    applyStimulus(1'b0, 1'b0, Q);
  endtask

  task automatic i2cStop();
    applyStimulus(1'b0, 1'b0, Q);
    applyStimulus(1'b1, 1'b0, Q);
    applyStimulus(1'b1, 1'b1, Q);
    applyStimulus(1'b1, 1'b1, Q);
  endtask

  task automatic sendBit(input logic b, input bit glitch);
    applyStimulus(1'b0, b, Q);
    applyStimulus(1'b1, b, Q);
    if (glitch) begin
      applyStimulus(1'b0, b, 2);
      applyStimulus(1'b1, b, Q - 2);
    end else begin
      applyStimulus(1'b1, b, Q);
    end
    applyStimulus(1'b0, b, Q);
  endtask

  task automatic recvBit(output logic b);
    applyStimulus(1'b0, 1'b1, Q);
    applyStimulus(1'b1, 1'b1, Q);
    b = sdaLine;
    applyStimulus(1'b1, 1'b1, Q);
    applyStimulus(1'b0, 1'b1, Q);
  endtask

  task automatic sendByte(input logic [7:0] data, input logic ack, input int glitchBit);
    logic a;
    expAck.push_back(ack);
    for (int i = 7; i >= 0; i--) sendBit(data[i], i == glitchBit);
    recvBit(a);
    checkOutput($sformatf("ack_%02h", data), {31'b0, a}, {31'b0, expAck.pop_front()});
  endtask

  task automatic recvByte(input logic ackToSend);
    logic [7:0] got;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recvBit(b);
      got[i] = b;
    end
    sendBit(ackToSend, 1'b0);
    checkOutput("rd_byte", {24'h0, got}, {24'h0, expRd.pop_front()});
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit hit, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    waitClk(4);
    checkOutput("rst_sda_t", {31'b0, i2c_sda_t}, 32'h1);
    checkOutput("rst_scl_t", {31'b0, i2c_scl_t}, 32'h1);
    checkOutput("rst_pin_o", {30'b0, i2c_scl_o, i2c_sda_o}, 32'h0);
    checkOutput("rst_wr_en", {31'b0, wr_en}, 32'h0);
    checkOutput("rst_wr_bus", {16'h0, wr_addr, wr_data}, 32'h0);
    checkOutput("rst_rd_addr", {24'h0, rd_addr}, 32'h0);
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    rst_n = 1'b1;
    waitClk(4);

    $display("[TB] write with auto-increment");
    i2cStart();
    sendByte(8'hA0, 1'b0, -1);
    checkOutput("busy_after_addr", {31'b0, busy}, 32'h1);
    sendByte(8'h10, 1'b0, -1);
    expWr.push_back({8'h10, 8'h5A});
    sendByte(8'h5A, 1'b0, -1);
    expWr.push_back({8'h11, 8'hC3});
    sendByte(8'hC3, 1'b0, -1);
    i2cStop();
    checkOutput("busy_after_stop", {31'b0, busy}, 32'h0);
    checkOutput("ptr_after_write", {24'h0, rd_addr}, 32'h12);
    checkOutput("wr_drained_write", expWr.size(), 32'h0);

    $display("[TB] read with repeated start");
    i2cStart();
    sendByte(8'hA0, 1'b0, -1);
    sendByte(8'h20, 1'b0, -1);
    i2cStart();
    sendByte(8'hA1, 1'b0, -1);
    expRd.push_back(8'hDF);
    recvByte(1'b0);
    expRd.push_back(8'hDE);
    recvByte(1'b1);
    checkOutput("busy_before_stop", {31'b0, busy}, 32'h1);
    i2cStop();
    checkOutput("busy_read_stop", {31'b0, busy}, 32'h0);
    checkOutput("ptr_after_read", {24'h0, rd_addr}, 32'h22);

    $display("[TB] address mismatch");
    lowSeen = 1'b0;
    busySeen = 1'b0;
    i2cStart();
    sendByte(8'hA4, 1'b1, -1);
    sendByte(8'h55, 1'b1, -1);
    i2cStop();
    checkOutput("mismatch_sda_low", {31'b0, lowSeen}, 32'h0);
    checkOutput("mismatch_busy", {31'b0, busySeen}, 32'h0);
    checkOutput("mismatch_ptr", {24'h0, rd_addr}, 32'h22);

    $display("[TB] pointer wrap and mid-byte abort");
    i2cStart();
    sendByte(8'hA0, 1'b0, -1);
    sendByte(8'hFF, 1'b0, -1);
    expWr.push_back({8'hFF, 8'h11});
    sendByte(8'h11, 1'b0, -1);
    expWr.push_back({8'h00, 8'h22});
    sendByte(8'h22, 1'b0, -1);
    partial = 8'h33;
    for (int i = 7; i >= 4; i--) sendBit(partial[i], 1'b0);
    checkOutput("ptr_wrapped", {24'h0, rd_addr}, 32'h01);
    i2cStart();
    sendByte(8'hA0, 1'b0, -1);
    sendByte(8'h40, 1'b0, -1);
    i2cStop();
    checkOutput("ptr_after_abort", {24'h0, rd_addr}, 32'h40);
    checkOutput("wr_drained_wrap", expWr.size(), 32'h0);

    $display("[TB] SCL glitch rejection");
    i2cStart();
    sendByte(8'hA0, 1'b0, -1);
    sendByte(8'h30, 1'b0, -1);
    expWr.push_back({8'h30, 8'h77});
    sendByte(8'h77, 1'b0, 3);
    i2cStop();
    checkOutput("ptr_after_glitch", {24'h0, rd_addr}, 32'h31);
    checkOutput("wr_drained_glitch", expWr.size(), 32'h0);

    $display("[TB] reset during read");
    i2cStart();
    sendByte(8'hA0, 1'b0, -1);
    sendByte(8'h50, 1'b0, -1);
    i2cStart();
    sendByte(8'hA1, 1'b0, -1);
    recvBit(bitVal);
    checkOutput("rd_bit7", {31'b0, bitVal}, 32'h1);
    applyStimulus(1'b0, 1'b1, Q);
    applyStimulus(1'b1, 1'b1, Q);
    checkOutput("rd_bit6_drive", {31'b0, i2c_sda_t}, 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_sda_t", {31'b0, i2c_sda_t}, 32'h1);
    checkOutput("async_rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("async_rst_rd_addr", {24'h0, rd_addr}, 32'h0);
    checkOutput("async_rst_wr", {15'h0, wr_en, wr_addr, wr_data}, 32'h0);
    waitClk(4);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 2 * Q);

    $display("[TB] general call address");
`ifdef I2C_GENERAL_CALL_EN
    i2cStart();
    sendByte(8'h00, 1'b0, -1);
    expWr.push_back({8'hFF, 8'h06});
    sendByte(8'h06, 1'b0, -1);
    i2cStop();
    checkOutput("gc_ptr_kept", {24'h0, rd_addr}, 32'h0);
`else
    i2cStart();
    sendByte(8'h00, 1'b1, -1);
    sendByte(8'h06, 1'b1, -1);
    i2cStop();
`endif
    i2cStart();
    sendByte(8'h01, 1'b1, -1);
    i2cStop();
    checkOutput("gc_read_busy", {31'b0, busy}, 32'h0);
    checkOutput("wr_drained_final", expWr.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
